// File: rtl/pixel_bram_arbiter.sv
// Arbiter sharing the single-port binarized image BRAM between the capture
// writer and two readers (cross finder = reader 0, QR sampler = reader 1).
// Grants are combinational; read data returns a fixed READ_LATENCY after the
// grant edge, tagged one-hot with the reader that issued it.
module pixel_bram_arbiter #(
   parameter int HEIGHT       = 480,
   parameter int WIDTH        = 480,
   parameter int ADDR_W       = 20,
   parameter int READ_LATENCY = 2,
   parameter int MAX_WR_BURST = 8
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  wr_req,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic                  wr_data,
   output logic                  wr_gnt,
   input  logic [1:0]            rd_req,
   input  logic [2*ADDR_W-1:0]   rd_addr,
   output logic [1:0]            rd_gnt,
   output logic                  rd_data,
   output logic [1:0]            rd_valid,
   output logic                  addr_err,
   output logic [ADDR_W-1:0]     bram_addr,
   output logic                  bram_din,
   output logic                  bram_we,
   input  logic                  bram_dout
);

   localparam logic [31:0] NPIX = 32'(HEIGHT * WIDTH);
   localparam int BURST_W = $clog2(MAX_WR_BURST + 1);
   localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_WR_BURST);
   localparam int LAST = READ_LATENCY - 1;

   logic                  r_rr_ptr;
   logic [BURST_W-1:0]    r_wr_burst;
   logic                  r_addr_err;
   logic [ADDR_W-1:0]     r_bram_addr;
   logic [1:0]            r_tag_pipe [READ_LATENCY];
   logic                  r_err_pipe [READ_LATENCY];

   logic                  w_wr_gnt;
   logic [1:0]            w_rd_gnt;
   logic                  w_any_gnt;
   logic [ADDR_W-1:0]     w_rd_addr0;
   logic [ADDR_W-1:0]     w_rd_addr1;
   logic [ADDR_W-1:0]     w_sel_addr;
   logic                  w_sel_err;
   logic [ADDR_W-1:0]     w_bram_addr;

   function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
      return (32'(a) < NPIX);
   endfunction

   assign w_rd_addr0 = rd_addr[ADDR_W-1:0];
   assign w_rd_addr1 = rd_addr[2*ADDR_W-1:ADDR_W];

   // Grant selection: writer first unless it has starved a waiting reader,
   // then round-robin between the readers. Reset suppresses every grant.
   always_comb begin
      w_wr_gnt = 1'b0;
      w_rd_gnt = 2'b00;
      if (!rst_in) begin
         if (wr_req && ((rd_req == 2'b00) || (r_wr_burst < BURST_MAX))) begin
            w_wr_gnt = 1'b1;
         end else if (rd_req == 2'b11) begin
            w_rd_gnt = r_rr_ptr ? 2'b10 : 2'b01;
         end else begin
            w_rd_gnt = rd_req;
         end
      end
   end

   assign w_any_gnt  = w_wr_gnt | (|w_rd_gnt);
   assign w_sel_addr = w_wr_gnt    ? wr_addr    :
                       w_rd_gnt[1] ? w_rd_addr1 : w_rd_addr0;
   assign w_sel_err  = w_any_gnt & ~addr_in_range(w_sel_addr);

   // An out-of-range access is still granted but steered to address 0 with
   // the write strobe suppressed so it can never corrupt the image.
   assign w_bram_addr = !w_any_gnt ? r_bram_addr :
                        w_sel_err  ? '0          : w_sel_addr;

   assign wr_gnt    = w_wr_gnt;
   assign rd_gnt    = w_rd_gnt;
   assign bram_addr = w_bram_addr;
   assign bram_we   = w_wr_gnt & ~w_sel_err;
   assign bram_din  = w_wr_gnt & wr_data;
   assign addr_err  = r_addr_err;
   assign rd_valid  = r_tag_pipe[LAST];
   assign rd_data   = (|r_tag_pipe[LAST]) & ~r_err_pipe[LAST] & bram_dout;

   // Hold the last issued address so idle cycles leave the BRAM port unchanged.
   always_ff @(posedge clk_in) begin
      if (w_any_gnt) r_bram_addr <= w_bram_addr;
   end

   // Round-robin pointer, write-burst counter and sticky address error.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_rr_ptr   <= 1'b0;
         r_wr_burst <= '0;
         r_addr_err <= 1'b0;
      end else begin
         if (|w_rd_gnt) r_rr_ptr <= ~w_rd_gnt[1];
         if ((|w_rd_gnt) || (rd_req == 2'b00)) begin
            r_wr_burst <= '0;
         end else if (w_wr_gnt && (r_wr_burst != BURST_MAX)) begin
            r_wr_burst <= r_wr_burst + 1'b1;
         end
         if (w_sel_err) r_addr_err <= 1'b1;
      end
   end

   // Return-tag pipeline: one stage per BRAM latency cycle, so the tag leaves
   // the last stage in the same cycle the BRAM presents the matching pixel.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         for (int i = 0; i < READ_LATENCY; i++) begin
            r_tag_pipe[i] <= 2'b00;
            r_err_pipe[i] <= 1'b0;
         end
      end else begin
         r_tag_pipe[0] <= w_rd_gnt;
         r_err_pipe[0] <= w_sel_err & (|w_rd_gnt);
         for (int i = 1; i < READ_LATENCY; i++) begin
            r_tag_pipe[i] <= r_tag_pipe[i-1];
            r_err_pipe[i] <= r_err_pipe[i-1];
         end
      end
   end

endmodule

// File: tb/tb_pixel_bram_arbiter.sv
// Directed bench for pixel_bram_arbiter with a behavioural 2-cycle BRAM.
module tb_pixel_bram_arbiter;

   logic        clk_in;
   logic        rst_in;
   logic        wr_req;
   logic [19:0] wr_addr;
   logic        wr_data;
   logic        wr_gnt;
   logic [1:0]  rd_req;
   logic [39:0] rd_addr;
   logic [1:0]  rd_gnt;
   logic        rd_data;
   logic [1:0]  rd_valid;
   logic        addr_err;
   logic [19:0] bram_addr;
   logic        bram_din;
   logic        bram_we;
   logic        bram_dout;

   int total = 0;
   int bad   = 0;

   pixel_bram_arbiter dut (
      .clk_in(clk_in), .rst_in(rst_in),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
      .rd_data(rd_data), .rd_valid(rd_valid), .addr_err(addr_err),
      .bram_addr(bram_addr), .bram_din(bram_din), .bram_we(bram_we),
      .bram_dout(bram_dout)
   );

   // Behavioural single-port BRAM, read-first, address and output registers.
   logic mem [0:230399];
   logic bram_q1;

   always @(posedge clk_in) begin
      if (bram_we) mem[bram_addr] <= bram_din;
   end

   always @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         bram_q1   <= 1'b0;
         bram_dout <= 1'b0;
      end else begin
         bram_q1   <= mem[bram_addr];
         bram_dout <= bram_q1;
      end
   end

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic preload(input logic [19:0] a, input logic d);
      tick();
      wr_req = 1'b1; wr_addr = a; wr_data = d;
      #1;
      check($sformatf("pre_wgnt_%0d", a), 32'(wr_gnt), 1);
      tick();
      wr_req = 1'b0;
   endtask

   initial begin
      rst_in = 1'b1; wr_req = 1'b0; wr_addr = '0; wr_data = 1'b0;
      rd_req = 2'b00; rd_addr = '0;
      #2;
      check("rst_wgnt",  32'(wr_gnt),   0);
      check("rst_rgnt",  32'(rd_gnt),   0);
      check("rst_we",    32'(bram_we),  0);
      check("rst_valid", 32'(rd_valid), 0);
      check("rst_data",  32'(rd_data),  0);
      check("rst_err",   32'(addr_err), 0);
      tick(); tick();
      rst_in = 1'b0;

      preload(20'd0, 1'b1);
      preload(20'd5, 1'b1);
      preload(20'd10, 1'b1);
      preload(20'd20, 1'b0);
      preload(20'd100, 1'b0);
      preload(20'd230399, 1'b1);
      tick();

      // both readers held: grants alternate from rr_ptr=0, returns follow
      for (int i = 0; i < 6; i++) begin
         tick();
         rd_req  = (i < 4) ? 2'b11 : 2'b00;
         rd_addr = {20'd20, 20'd10};
         #1;
         check($sformatf("rr_gnt%0d", i), 32'(rd_gnt),
               (i < 4) ? ((i % 2 == 0) ? 1 : 2) : 0);
         check($sformatf("rr_vld%0d", i), 32'(rd_valid),
               (i < 2) ? 0 : (((i - 2) % 2 == 0) ? 1 : 2));
         check($sformatf("rr_dat%0d", i), 32'(rd_data),
               (i >= 2 && ((i - 2) % 2 == 0)) ? 1 : 0);
      end

      // single reader, fixed 2-cycle return
      tick();
      rd_req = 2'b01; rd_addr[19:0] = 20'd5;
      #1;
      check("sr_gnt",  32'(rd_gnt),    1);
      check("sr_addr", 32'(bram_addr), 5);
      check("sr_we",   32'(bram_we),   0);
      tick();
      rd_req = 2'b00;
      #1;
      check("sr_vld1", 32'(rd_valid), 0);
      tick();
      check("sr_vld2", 32'(rd_valid), 1);
      check("sr_dat2", 32'(rd_data),  1);
      tick();
      check("sr_vld3", 32'(rd_valid), 0);

      // writer plus reader 0: 8 writes then 1 read, repeating
      for (int i = 0; i < 27; i++) begin
         tick();
         wr_req = 1'b1; wr_addr = 20'd2000; wr_data = 1'b0;
         rd_req = 2'b01; rd_addr[19:0] = 20'd7;
         #1;
         check($sformatf("wb_wgnt%0d", i), 32'(wr_gnt), (i % 9 == 8) ? 0 : 1);
         check($sformatf("wb_rgnt%0d", i), 32'(rd_gnt), (i % 9 == 8) ? 1 : 0);
      end
      tick();
      wr_req = 1'b0; rd_req = 2'b00;
      tick(); tick();

      // write then read same address next cycle, then out-of-range accesses
      tick();
      wr_req = 1'b1; wr_addr = 20'd100; wr_data = 1'b1;
      #1;
      check("wr_gnt",  32'(wr_gnt),    1);
      check("wr_we",   32'(bram_we),   1);
      check("wr_addr", 32'(bram_addr), 100);
      check("wr_din",  32'(bram_din),  1);
      tick();
      wr_req = 1'b0; rd_req = 2'b01; rd_addr[19:0] = 20'd100;
      #1;
      check("wrr_gnt", 32'(rd_gnt), 1);
      tick();
      rd_addr[19:0] = 20'd230400;
      #1;
      check("oor_gnt",  32'(rd_gnt),    1);
      check("oor_addr", 32'(bram_addr), 0);
      check("oor_we",   32'(bram_we),   0);
      check("oor_err0", 32'(addr_err),  0);
      tick();
      rd_addr[19:0] = 20'd230399;
      #1;
      check("wrr_vld",  32'(rd_valid),  1);
      check("wrr_dat",  32'(rd_data),   1);
      check("oor_err1", 32'(addr_err),  1);
      check("bnd_addr", 32'(bram_addr), 230399);
      tick();
      rd_req = 2'b00;
      #1;
      check("oor_vld", 32'(rd_valid), 1);
      check("oor_dat", 32'(rd_data),  0);
      tick();
      check("bnd_vld",  32'(rd_valid),  1);
      check("bnd_dat",  32'(rd_data),   1);
      check("idle_adr", 32'(bram_addr), 230399);
      tick();
      wr_req = 1'b1; wr_addr = 20'd230400; wr_data = 1'b0;
      #1;
      check("oow_gnt",  32'(wr_gnt),    1);
      check("oow_we",   32'(bram_we),   0);
      check("oow_addr", 32'(bram_addr), 0);
      tick();
      wr_req = 1'b0; rd_req = 2'b01; rd_addr[19:0] = 20'd0;
      tick();
      rd_req = 2'b00;
      tick();
      check("oow_vld", 32'(rd_valid), 1);
      check("oow_dat", 32'(rd_data),  1);
      check("err_stk", 32'(addr_err), 1);

      // asynchronous reset with two reads in flight
      tick();
      rd_req = 2'b01; rd_addr[19:0] = 20'd5;
      tick();
      rd_req = 2'b10; rd_addr[39:20] = 20'd10;
      #1;
      check("fl_gnt", 32'(rd_gnt), 2);
      tick();
      wr_req = 1'b1; rd_req = 2'b11;
      check("fl_vld", 32'(rd_valid), 1);
      #1;
      rst_in = 1'b1;
      #1;
      check("ar_wgnt", 32'(wr_gnt),   0);
      check("ar_rgnt", 32'(rd_gnt),   0);
      check("ar_we",   32'(bram_we),  0);
      check("ar_vld",  32'(rd_valid), 0);
      check("ar_dat",  32'(rd_data),  0);
      check("ar_err",  32'(addr_err), 0);
      wr_req = 1'b0; rd_req = 2'b00;
      #1;
      rst_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("ar_post%0d", i), 32'(rd_valid), 0);
      end
      rd_req = 2'b01; rd_addr[19:0] = 20'd5;
      #1;
      check("pr_gnt", 32'(rd_gnt), 1);
      tick();
      rd_req = 2'b00;
      tick();
      check("pr_vld", 32'(rd_valid), 1);
      check("pr_dat", 32'(rd_data),  1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
